// File: rtl/uart_rx_if.sv
// Bus between a UART receiver and its user: serial line and baud tick in,
// received word and status out. parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_err;

    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err
    );
    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err
    );
`else
    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err
    );
    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err
    );
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, with stop-bit framing check.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(SB_TICK);
    localparam int BW = $clog2(DBIT);
    localparam logic [TW-1:0] MID    = TW'(7);
    localparam logic [TW-1:0] LAST_D = TW'(15);
    localparam logic [TW-1:0] LAST_S = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            meta_q  <= 1'b1;
            rx_s_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            meta_q  <= bus.rx;
            rx_s_q  <= meta_q;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (tick_q == MID) begin
                        // A start bit that is high again at mid-bit was noise
                        state_d = rx_s_q ? IDLE : DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (tick_q == LAST_D) begin
                        tick_d = '0;
                        sh_d   = {rx_s_q, sh_q[DBIT-1:1]};
                        if (bit_q == LAST_B) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (tick_q == LAST_D) begin
                        tick_d  = '0;
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (bus.s_tick) begin
                    if (tick_q == LAST_S) begin
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d = 1'b0;
        dout_d = dout_q;
        ferr_d = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d = perr_q;
`endif
        if (state_q == STOP && bus.s_tick && tick_q == LAST_S) begin
            done_d = 1'b1;
            dout_d = sh_q;
            ferr_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d = (^sh_q) ^ par_q;
`endif
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames built bit by bit on the line,
// results compared with a frame-level model of what each frame should yield.
module tb_uart_rx;
    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

    logic clk;
    logic reset;
    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   dbl    = 0;
    logic prev   = 1'b0;
    rec_t obs_q[$];
    rec_t exp_q[$];
    logic [7:0] last_d = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        bus.s_tick = 1'b0;
        forever begin
            repeat (3) begin
                @(negedge clk);
                bus.s_tick = 1'b0;
            end
            @(negedge clk);
            bus.s_tick = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.rx_done_tick) begin
`ifdef UART_RX_PARITY_EN
            obs_q.push_back({bus.dout, bus.frame_err, bus.parity_err});
`else
            obs_q.push_back({bus.dout, bus.frame_err, 1'b0});
`endif
            if (prev) dbl++;
        end
        prev = bus.rx_done_tick;
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            #1;
            if (bus.s_tick) k++;
        end
    endtask

    // Frame-level model: word delivered as sent, framing from stop level,
    // even parity error when data and parity bit together are odd.
    function automatic rec_t model(input logic [7:0] d, input logic stop_ok,
                                   input logic pbit);
        rec_t r;
        r.d  = d;
        r.fe = ~stop_ok;
`ifdef UART_RX_PARITY_EN
        r.pe = (^d) ^ pbit;
`else
        r.pe = 1'b0;
        if (pbit === 1'bx) r.pe = 1'b0;
`endif
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input logic pbit);
        exp_q.push_back(model(d, stop_ok, pbit));
        last_d = d;
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = pbit;
        wait_ticks(16);
`endif
        if (stop_ok) begin
            bus.rx = 1'b1;
            wait_ticks(16);
        end else begin
            bus.rx = 1'b0;
            wait_ticks(10);
            bus.rx = 1'b1;
            wait_ticks(6);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        bus.rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h exp 00", bus.dout);
        end
        checks++;
        if (bus.rx_done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b exp 0", bus.rx_done_tick);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr got %b exp 0", bus.frame_err);
        end
        reset = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_a5;
        obs_q.delete();
        exp_q.delete();
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL a5_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL a5_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch;
        obs_q.delete();
        bus.rx = 1'b0;
        wait_ticks(5);
        bus.rx = 1'b1;
        wait_ticks(24);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch_count got %0d exp 0", obs_q.size());
        end
        checks++;
        if (bus.dout !== last_d) begin
            errors++;
            $display("FAIL glitch_dout got %h exp %h", bus.dout, last_d);
        end
    endtask

    task automatic test_frame_err;
        obs_q.delete();
        exp_q.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(16);
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_hold got %b exp 1", bus.frame_err);
        end
        send_frame(8'h00, 1'b1, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL ferr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ferr_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_q.delete();
        exp_q.delete();
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (dbl !== 0) begin
            errors++;
            $display("FAIL done_width got %0d long pulses exp 0", dbl);
        end
    endtask

    task automatic test_reset_abort;
        obs_q.delete();
        exp_q.delete();
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b1;
            wait_ticks(16);
        end
        wait_ticks(8);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL abort_dout_rst got %h exp 00", bus.dout);
        end
        reset = 1'b1;
        wait_ticks(20);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_nopulse got %0d exp 0", obs_q.size());
        end
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL abort_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        obs_q.delete();
        exp_q.delete();
        for (int n = 0; n < 8; n++) begin
            send_frame(8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
            wait_ticks($urandom_range(0, 3));
        end
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.dout !== last_d) begin
            errors++;
            $display("FAIL rand_dout_hold got %h exp %h", bus.dout, last_d);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        obs_q.delete();
        exp_q.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL par_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL par_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask
`endif

    initial begin
        bus.rx = 1'b1;
        reset  = 1'b0;
        test_reset();
        test_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame, legal range 5..8.
REQ-002 Parameter SB_TICK, default 16: s_tick count for the stop bit, legal values 16, 24, 32; stop tick counter width SHALL hold SB_TICK-1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 s_tick  input  1  one-clk strobe at 16x baud rate from the shared baud generator.
REQ-007 dout  output  DBIT  last received data word, LSB first on the line.
REQ-008 rx_done_tick  output  1  one-clk pulse marking a completed frame.
REQ-009 frame_err  output  1  stop bit sampled low on the last completed frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, initialised to 1; the FSM SHALL use only the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY per REQ-024); a frame's tick counter SHALL advance only on clocks with s_tick=1 and hold otherwise.
REQ-012 IDLE: when rx_s=0, go to START and clear the tick counter, regardless of s_tick.
REQ-013 START: on the s_tick where the counter equals 7 (mid start bit), go to DATA with the tick and bit counters cleared if rx_s=0, or return to IDLE with no output change if rx_s=1 (glitch rejection).
REQ-014 DATA: on the s_tick where the counter equals 15, sample rx_s into the MSB of the shift register, shift right, and clear the counter; after DBIT samples, go to STOP.
REQ-015 STOP: on the s_tick where the counter equals SB_TICK-1, return to IDLE and update dout, frame_err (=~rx_s), and rx_done_tick.
REQ-016 dout, frame_err and rx_done_tick SHALL be registered, and SHALL change together in the clock after the final stop s_tick.
REQ-017 rx_done_tick SHALL be high for exactly one clk per frame, including frames with frame_err=1.
REQ-018 dout and frame_err SHALL hold their values until the next frame completes.
REQ-019 A frame with frame_err=1 SHALL still deliver dout; the FSM SHALL then wait in IDLE for rx_s=0 (a break condition SHALL restart reception immediately).
REQ-020 Back-to-back frames SHALL be received without loss: in the clock after leaving STOP, IDLE SHALL accept a start edge.

Reset
REQ-021 On reset=0: state IDLE, all counters 0, shift register 0, synchronizer flops 1, dout=0, rx_done_tick=0, frame_err=0 (and parity_err=0 if present).
REQ-022 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick; on reset release, reception SHALL restart only on a new start edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL select the parity option.
REQ-024 With UART_RX_PARITY_EN defined: add output parity_err (1 bit, registered); add state PARITY between DATA and STOP, sampling one even-parity bit at counter 15; parity_err = XOR of the data bits and the parity bit, updated with dout.
REQ-025 Without UART_RX_PARITY_EN: no parity_err port and no PARITY state; DATA SHALL go directly to STOP.

Verification
REQ-026 Send 0xA5 at 16 ticks/bit with a valid stop bit -> exactly one rx_done_tick, dout=0xA5, frame_err=0.
REQ-027 Pulse rx low for 5 s_ticks in IDLE -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
REQ-028 Send 0x3C with the stop bit held low -> rx_done_tick, dout=0x3C, frame_err=1; next frame 0x00 received correctly.
REQ-029 Send 0x55 then 0xAA with no idle gap -> two rx_done_tick pulses, dout=0x55 then 0xAA.
REQ-030 Assert reset at data bit 4 of 0xFF, release it, then send 0x81 -> no pulse for the aborted frame, dout=0x81 after the second frame.
REQ-031 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
